// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Provides the forwarding-select encoding used on fwd_a_ctrl/fwd_b_ctrl
// and the controller state encoding exported on the state port.
package pipe_hazard_ctrl_pkg;

  // Operand source selects for the ID-stage forwarding muxes.
  localparam logic [1:0] FwdRf      = 2'd0;  // register file
  localparam logic [1:0] FwdExeAlu  = 2'd1;  // EXE ALU result
  localparam logic [1:0] FwdMemAlu  = 2'd2;  // ALU result now in MEM
  localparam logic [1:0] FwdMemLoad = 2'd3;  // load data returned in MEM

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StHalt    = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Combinational forwarding and load-use detection for the ID stage.
// Ports:
//   id_*            register-use info of the instruction in ID
//   exe_*, mem_*    write-back info of the instructions in EXE and MEM
//   fwd_a_ctrl/b    operand source selects for rs/rt
//   fwd_m           forward MEM load data into the store data of EXE
//   load_stall      ID must hold one cycle behind a load in EXE
module pipe_hazard_ctrl_fwd
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_is_store,
  input  logic              exe_wb_wen,
  input  logic [REG_AW-1:0] exe_regw_addr,
  input  logic              exe_is_load,
  input  logic              mem_wb_wen,
  input  logic [REG_AW-1:0] mem_regw_addr,
  input  logic              mem_is_load,
  output logic [1:0]        fwd_a_ctrl,
  output logic [1:0]        fwd_b_ctrl,
  output logic              fwd_m,
  output logic              load_stall
);

  logic exe_hit_rs, exe_hit_rt, mem_hit_rs, mem_hit_rt;

  // r0 is hard-wired zero, so a write to it never produces a hazard.
  assign exe_hit_rs = exe_wb_wen && (exe_regw_addr == id_rs_addr) && (id_rs_addr != '0);
  assign exe_hit_rt = exe_wb_wen && (exe_regw_addr == id_rt_addr) && (id_rt_addr != '0);
  assign mem_hit_rs = mem_wb_wen && (mem_regw_addr == id_rs_addr) && (id_rs_addr != '0);
  assign mem_hit_rt = mem_wb_wen && (mem_regw_addr == id_rt_addr) && (id_rt_addr != '0);

  // The youngest producer (EXE) wins over MEM.
  always_comb begin
    fwd_a_ctrl = FwdRf;
    if (exe_hit_rs) begin
      fwd_a_ctrl = FwdExeAlu;
    end else if (mem_hit_rs) begin
      fwd_a_ctrl = mem_is_load ? FwdMemLoad : FwdMemAlu;
    end

    fwd_b_ctrl = FwdRf;
    if (exe_hit_rt) begin
      fwd_b_ctrl = FwdExeAlu;
    end else if (mem_hit_rt) begin
      fwd_b_ctrl = mem_is_load ? FwdMemLoad : FwdMemAlu;
    end
  end

  // A store only needs rt as data in MEM, so a load feeding it is bypassed
  // one stage later instead of stalling.
  assign fwd_m = id_is_store && id_rt_used && exe_is_load && exe_hit_rt;

  assign load_stall = exe_is_load &&
                      ((id_rs_used && exe_hit_rs) ||
                       (id_rt_used && exe_hit_rt && !id_is_store));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage MIPS core.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_*, exe_*, mem_*       decoded register-use and write-back info
//   mem_req, mem_ready       MEM-stage access handshake
//   debug_en, debug_step     debug halt and single-step (rising edge)
//   *_en, *_rst              per-stage enables and synchronous clears
//   fwd_a_ctrl/b, fwd_m      forwarding selects
//   state                    0 run, 1 memory wait, 2 halt
//   mem_timeout              sticky memory-wait timeout
//   stall_cycles             saturating count of cycles with ID held
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned WAIT_MAX = 255,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_is_store,
  input  logic              id_redirect,
  input  logic              exe_wb_wen,
  input  logic [REG_AW-1:0] exe_regw_addr,
  input  logic              exe_is_load,
  input  logic              mem_wb_wen,
  input  logic [REG_AW-1:0] mem_regw_addr,
  input  logic              mem_is_load,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              debug_en,
  input  logic              debug_step,
  output logic              if_en,
  output logic              id_en,
  output logic              exe_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic              if_rst,
  output logic              id_rst,
  output logic              exe_rst,
  output logic              mem_rst,
  output logic              wb_rst,
  output logic [1:0]        fwd_a_ctrl,
  output logic [1:0]        fwd_b_ctrl,
  output logic              fwd_m,
  output logic [1:0]        state,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [CNT_W-1:0] WaitMaxC = CNT_W'(WAIT_MAX);
  localparam logic [CNT_W-1:0] OneC     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             timeout_q, timeout_d;
  logic             step_prev_q;

  logic load_stall;
  logic step;
  logic wait_active;
  logic halted;

  pipe_hazard_ctrl_fwd #(
    .REG_AW(REG_AW)
  ) u_fwd (
    .id_rs_addr   (id_rs_addr),
    .id_rt_addr   (id_rt_addr),
    .id_rs_used   (id_rs_used),
    .id_rt_used   (id_rt_used),
    .id_is_store  (id_is_store),
    .exe_wb_wen   (exe_wb_wen),
    .exe_regw_addr(exe_regw_addr),
    .exe_is_load  (exe_is_load),
    .mem_wb_wen   (mem_wb_wen),
    .mem_regw_addr(mem_regw_addr),
    .mem_is_load  (mem_is_load),
    .fwd_a_ctrl   (fwd_a_ctrl),
    .fwd_b_ctrl   (fwd_b_ctrl),
    .fwd_m        (fwd_m),
    .load_stall   (load_stall)
  );

  assign step = debug_step && !step_prev_q;

  // While halted the pipe is frozen, so a pending access only counts as a
  // wait in the cycle a step lets it advance.
  assign wait_active = mem_req && !mem_ready && ((state_q != StHalt) || step);
  assign halted      = (state_q == StHalt) && !step;

  // State register and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      stall_q     <= '0;
      timeout_q   <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_q     <= stall_d;
      timeout_q   <= timeout_d;
      step_prev_q <= debug_step;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (wait_active) begin
          state_d = StMemWait;
        end else if (debug_en) begin
          state_d = StHalt;
        end
      end
      StMemWait: begin
        if (!wait_active) begin
          state_d = debug_en ? StHalt : StRun;
        end
      end
      StHalt: begin
        if (wait_active) begin
          state_d = StMemWait;
        end else if (!debug_en) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Stage enables and clears, highest priority first.
  always_comb begin
    if_en   = 1'b1;
    id_en   = 1'b1;
    exe_en  = 1'b1;
    mem_en  = 1'b1;
    wb_en   = 1'b1;
    if_rst  = 1'b0;
    id_rst  = 1'b0;
    exe_rst = 1'b0;
    mem_rst = 1'b0;
    wb_rst  = 1'b0;
    if (rst) begin
      if_rst  = 1'b1;
      id_rst  = 1'b1;
      exe_rst = 1'b1;
      mem_rst = 1'b1;
      wb_rst  = 1'b1;
    end else if (wait_active) begin
      if_en  = 1'b0;
      id_en  = 1'b0;
      exe_en = 1'b0;
      mem_en = 1'b0;
      wb_rst = 1'b1;
    end else if (halted) begin
      if_en  = 1'b0;
      id_en  = 1'b0;
      exe_en = 1'b0;
      mem_en = 1'b0;
      wb_en  = 1'b0;
    end else if (load_stall) begin
      // Any redirect is dropped; the branch re-resolves once the stall clears.
      if_en   = 1'b0;
      id_en   = 1'b0;
      exe_rst = 1'b1;
    end else if (id_redirect) begin
      id_rst = 1'b1;
    end
  end

  // Counter next-state.
  always_comb begin
    wait_cnt_d = '0;
    if (wait_active) begin
      wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + OneC;
    end
    timeout_d = timeout_q || (wait_active && (wait_cnt_d >= WaitMaxC));
    stall_d   = stall_q;
    if (!id_en && (stall_q != '1)) begin
      stall_d = stall_q + OneC;
    end
  end

  assign state        = state_q;
  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (WAIT_MAX = 2).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs_addr, id_rt_addr, exe_regw_addr, mem_regw_addr;
  logic       id_rs_used, id_rt_used, id_is_store, id_redirect;
  logic       exe_wb_wen, exe_is_load, mem_wb_wen, mem_is_load;
  logic       mem_req, mem_ready, debug_en, debug_step;
  logic       if_en, id_en, exe_en, mem_en, wb_en;
  logic       if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic [1:0] fwd_a_ctrl, fwd_b_ctrl, state;
  logic       fwd_m, mem_timeout;
  logic [15:0] stall_cycles;

  logic [4:0] en_v, rst_v;
  assign en_v  = {if_en, id_en, exe_en, mem_en, wb_en};
  assign rst_v = {if_rst, id_rst, exe_rst, mem_rst, wb_rst};

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_AW  (5),
    .WAIT_MAX(2),
    .CNT_W   (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs_addr   (id_rs_addr),
    .id_rt_addr   (id_rt_addr),
    .id_rs_used   (id_rs_used),
    .id_rt_used   (id_rt_used),
    .id_is_store  (id_is_store),
    .id_redirect  (id_redirect),
    .exe_wb_wen   (exe_wb_wen),
    .exe_regw_addr(exe_regw_addr),
    .exe_is_load  (exe_is_load),
    .mem_wb_wen   (mem_wb_wen),
    .mem_regw_addr(mem_regw_addr),
    .mem_is_load  (mem_is_load),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .debug_en     (debug_en),
    .debug_step   (debug_step),
    .if_en        (if_en),
    .id_en        (id_en),
    .exe_en       (exe_en),
    .mem_en       (mem_en),
    .wb_en        (wb_en),
    .if_rst       (if_rst),
    .id_rst       (id_rst),
    .exe_rst      (exe_rst),
    .mem_rst      (mem_rst),
    .wb_rst       (wb_rst),
    .fwd_a_ctrl   (fwd_a_ctrl),
    .fwd_b_ctrl   (fwd_b_ctrl),
    .fwd_m        (fwd_m),
    .state        (state),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs_addr = 0; id_rt_addr = 0; id_rs_used = 0; id_rt_used = 0;
    id_is_store = 0; id_redirect = 0;
    exe_wb_wen = 0; exe_regw_addr = 0; exe_is_load = 0;
    mem_wb_wen = 0; mem_regw_addr = 0; mem_is_load = 0;
    mem_req = 0; mem_ready = 0; debug_en = 0; debug_step = 0;
  endtask

  // Outputs are sampled 1-2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    settle();
    chk("rst_clears", {27'd0, rst_v}, 32'h1f);
    chk("rst_enables", {27'd0, en_v}, 32'h1f);
    tick();
    chk("rst_state", {30'd0, state}, 0);
    chk("rst_stall", {16'd0, stall_cycles}, 0);
    chk("rst_timeout", {31'd0, mem_timeout}, 0);
    rst = 1'b0;

    // EXE add r3 ; ID add r4,r3,r3
    exe_wb_wen = 1; exe_regw_addr = 3;
    id_rs_addr = 3; id_rt_addr = 3; id_rs_used = 1; id_rt_used = 1;
    settle();
    chk("exe_fwd_a", {30'd0, fwd_a_ctrl}, 1);
    chk("exe_fwd_b", {30'd0, fwd_b_ctrl}, 1);
    chk("exe_fwd_en", {27'd0, en_v}, 32'h1f);
    exe_regw_addr = 0; id_rs_addr = 0; id_rt_addr = 0;
    settle();
    chk("r0_fwd_a", {30'd0, fwd_a_ctrl}, 0);
    chk("r0_fwd_b", {30'd0, fwd_b_ctrl}, 0);
    // MEM ALU match, then EXE overriding it
    exe_wb_wen = 0; mem_wb_wen = 1; mem_regw_addr = 7; id_rs_addr = 7;
    settle();
    chk("mem_alu_fwd_a", {30'd0, fwd_a_ctrl}, 2);
    exe_wb_wen = 1; exe_regw_addr = 7;
    settle();
    chk("exe_over_mem", {30'd0, fwd_a_ctrl}, 1);
    idle();

    // EXE lw r5 ; ID add r6,r5,r1
    exe_wb_wen = 1; exe_is_load = 1; exe_regw_addr = 5;
    id_rs_addr = 5; id_rt_addr = 1; id_rs_used = 1; id_rt_used = 1;
    settle();
    chk("lu_en", {27'd0, en_v}, 32'h07);
    chk("lu_rst", {27'd0, rst_v}, 32'h04);
    chk("lu_stall_before", {16'd0, stall_cycles}, 0);
    tick();
    chk("lu_stall_after", {16'd0, stall_cycles}, 1);
    exe_wb_wen = 0; exe_is_load = 0; exe_regw_addr = 0;
    mem_wb_wen = 1; mem_is_load = 1; mem_regw_addr = 5;
    settle();
    chk("lu_mem_load_fwd", {30'd0, fwd_a_ctrl}, 3);
    chk("lu_resume_en", {27'd0, en_v}, 32'h1f);
    idle();

    // EXE lw r5 ; ID sw r5,0(r2)
    exe_wb_wen = 1; exe_is_load = 1; exe_regw_addr = 5;
    id_is_store = 1; id_rs_addr = 2; id_rs_used = 1; id_rt_addr = 5; id_rt_used = 1;
    settle();
    chk("sw_fwd_m", {31'd0, fwd_m}, 1);
    chk("sw_no_stall", {27'd0, en_v}, 32'h1f);
    // ID lw r5,0(r5): base depends on the load
    id_is_store = 0; id_rs_addr = 5; id_rt_used = 0;
    settle();
    chk("lw_base_fwd_m", {31'd0, fwd_m}, 0);
    chk("lw_base_stall", {27'd0, en_v}, 32'h07);
    tick();
    chk("lw_base_count", {16'd0, stall_cycles}, 2);
    idle();

    // Redirect alone, then redirect under a load stall
    id_redirect = 1;
    settle();
    chk("redir_rst", {27'd0, rst_v}, 32'h08);
    chk("redir_en", {27'd0, en_v}, 32'h1f);
    exe_wb_wen = 1; exe_is_load = 1; exe_regw_addr = 5; id_rs_addr = 5; id_rs_used = 1;
    settle();
    chk("redir_stall_rst", {27'd0, rst_v}, 32'h04);
    chk("redir_stall_en", {27'd0, en_v}, 32'h07);
    tick();
    chk("redir_stall_count", {16'd0, stall_cycles}, 3);
    idle();

    // Memory wait of three cycles, WAIT_MAX = 2
    mem_req = 1;
    settle();
    chk("mw_en_first", {27'd0, en_v}, 32'h01);
    chk("mw_rst_first", {27'd0, rst_v}, 32'h01);
    tick();
    chk("mw_state1", {30'd0, state}, 1);
    chk("mw_timeout1", {31'd0, mem_timeout}, 0);
    chk("mw_en_wait", {27'd0, en_v}, 32'h01);
    tick();
    chk("mw_state2", {30'd0, state}, 1);
    chk("mw_timeout2", {31'd0, mem_timeout}, 1);
    tick();
    chk("mw_state3", {30'd0, state}, 1);
    chk("mw_stall3", {16'd0, stall_cycles}, 6);
    mem_ready = 1;
    settle();
    chk("mw_ready_en", {27'd0, en_v}, 32'h1f);
    chk("mw_ready_rst", {27'd0, rst_v}, 0);
    tick();
    chk("mw_exit_state", {30'd0, state}, 0);
    chk("mw_timeout_sticky", {31'd0, mem_timeout}, 1);
    chk("mw_exit_stall", {16'd0, stall_cycles}, 6);
    idle();

    // Reset while waiting
    mem_req = 1;
    tick();
    chk("rw_state", {30'd0, state}, 1);
    rst = 1;
    tick();
    chk("rw_rst_state", {30'd0, state}, 0);
    chk("rw_rst_stall", {16'd0, stall_cycles}, 0);
    chk("rw_rst_timeout", {31'd0, mem_timeout}, 0);
    rst = 0;
    idle();

    // Debug halt and single step
    debug_en = 1;
    settle();
    chk("dbg_enter_en", {27'd0, en_v}, 32'h1f);
    tick();
    chk("dbg_state", {30'd0, state}, 2);
    chk("dbg_halt_en", {27'd0, en_v}, 0);
    tick();
    chk("dbg_halt_count", {16'd0, stall_cycles}, 1);
    debug_step = 1;
    settle();
    chk("dbg_step_en", {27'd0, en_v}, 32'h1f);
    tick();
    chk("dbg_step_count", {16'd0, stall_cycles}, 1);
    for (int i = 0; i < 3; i++) begin
      chk("dbg_held_en", {27'd0, en_v}, 0);
      tick();
      chk("dbg_held_count", {16'd0, stall_cycles}, 2 + i);
    end
    chk("dbg_held_state", {30'd0, state}, 2);
    debug_step = 0; debug_en = 0;
    settle();
    chk("dbg_exit_en", {27'd0, en_v}, 0);
    tick();
    chk("dbg_exit_state", {30'd0, state}, 0);
    chk("dbg_exit_count", {16'd0, stall_cycles}, 5);
    chk("dbg_run_en", {27'd0, en_v}, 32'h1f);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and pipeline-control unit for the 5-stage MIPS core. It generates per-stage enable/reset, ID-stage forwarding selects and store-data forwarding, and load-use stalls. It also adds behaviour the current controller lacks: a variable-latency memory wait FSM with timeout, ID-resolved branch squash, edge-triggered debug single-step, and a saturating stall counter. It sits beside the instruction decoder and consumes decoded register-use flags from ID plus write-back info from EXE and MEM.

Parameters:
REG_AW, 5, register address width
WAIT_MAX, 255, memory-wait cycles before mem_timeout is flagged (must be 1..2^CNT_W-1)
CNT_W, 16, width of stall_cycles and wait counter

Ports:
clk  in  1  main clock
rst  in  1  synchronous reset, active-high
id_rs_addr  in  REG_AW  rs of ID instruction
id_rt_addr  in  REG_AW  rt of ID instruction
id_rs_used  in  1  ID reads rs
id_rt_used  in  1  ID reads rt
id_is_store  in  1  ID instruction is store
id_redirect  in  1  ID resolved a taken branch/jump
exe_wb_wen  in  1  EXE writes register
exe_regw_addr  in  REG_AW  EXE dest register
exe_is_load  in  1  EXE is load
mem_wb_wen  in  1  MEM writes register
mem_regw_addr  in  REG_AW  MEM dest register
mem_is_load  in  1  MEM is load
mem_req  in  1  MEM-stage memory access active
mem_ready  in  1  memory completes access this cycle
debug_en  in  1  debug halt mode
debug_step  in  1  step request (level; rising edge counts)
if_en/id_en/exe_en/mem_en/wb_en  out  1 each  stage enables
if_rst/id_rst/exe_rst/mem_rst/wb_rst  out  1 each  stage synchronous clears
fwd_a_ctrl  out  2  rs select: 0 RF, 1 EXE ALU out, 2 MEM ALU in, 3 MEM load out
fwd_b_ctrl  out  2  rt select, same encoding
fwd_m  out  1  forward MEM load data to store data of EXE
state  out  2  0 RUN, 1 MEM_WAIT, 2 HALT
mem_timeout  out  1  sticky timeout flag
stall_cycles  out  CNT_W  saturating count of non-advancing cycles

Behaviour:
- Reset (rst=1 at clk edge): state=RUN, wait_cnt=0, stall_cycles=0, mem_timeout=0, step_prev=0. While rst=1, all *_rst=1 and all *_en=1 combinationally.
- Forwarding (combinational): no forwarding for register 0. MEM match selects 2, or 3 if mem_is_load. EXE match overrides with 1. Applies independently to rs and rt.
- fwd_m=1 when id_is_store & id_rt_used & exe_is_load & exe_wb_wen & exe_regw_addr==id_rt_addr≠0. No stall in this case.
- load_stall=1 when exe_is_load & exe_wb_wen & dest≠0 & ((rs_used & rs match) | (rt_used & rt match & ~id_is_store)).
- Control priority per cycle: rst > memory wait > HALT > load_stall > redirect > normal.
- Memory wait: condition mem_req & ~mem_ready.
  - if/id/exe/mem_en=0; wb_rst=1 (bubble into WB).
  - RUN→MEM_WAIT on first such cycle. Stays while the condition holds. →RUN (or HALT if debug_en) in the cycle mem_ready=1, in which the pipe advances normally.
  - wait_cnt increments per waiting cycle and clears on exit. When wait_cnt reaches WAIT_MAX, mem_timeout is set; it stays set until rst.
- HALT: entered from RUN when debug_en=1 and no wait is pending. All en=0.
  - A step occurs when debug_step=1 & step_prev=0 (step_prev is the registered debug_step). In that cycle all en=1 and load_stall/redirect rules apply. Exactly one advance per rising edge.
  - debug_en=0 → RUN next cycle.
  - A mem wait arising during a step → MEM_WAIT.
- load_stall: if_en=0, id_en=0, exe_rst=1. Any redirect in the same cycle is ignored; the branch re-resolves next cycle.
- redirect (no stall): id_rst=1 squashes the wrong-path fetch. All en=1.
- stall_cycles increments (saturating at all-ones) every cycle in which id_en=0, including HALT.
- rst while in MEM_WAIT or HALT returns to RUN immediately.

Decomposition:
- Shared package/header (alongside mips_define.vh): FWD_RF/FWD_EXE_ALU/FWD_MEM_ALU/FWD_MEM_LOAD, ST_RUN/ST_MEM_WAIT/ST_HALT.
- One natural sub-module: hazard_fwd_unit (pure combinational forwarding + load_stall + fwd_m). The FSM, counters and stage-control muxing stay in the top.

Test Plan:
- EXE add r3, ID add r4,r3,r3 → fwd_a=fwd_b=1, no stall. Same with EXE dest r0 → fwd_a=fwd_b=0.
- EXE lw r5, ID add r6,r5,r1 → one cycle if_en=id_en=0, exe_rst=1, stall_cycles 0→1. Next cycle with the load in MEM → fwd_a=3.
- EXE lw r5, ID sw r5,0(r2) → fwd_m=1, no stall. Same with ID lw r5 base=r5 → stall.
- mem_req=1, mem_ready=0 for 3 cycles → state=1 for 3 cycles, if..mem_en=0, wb_rst=1. Pipe advances on the ready cycle, then state=0. With WAIT_MAX=2 → mem_timeout=1 and stays 1.
- debug_en=1 → state=2, all en=0. debug_step 0→1 held 4 cycles → exactly one cycle of all en=1, stall_cycles counts the other halted cycles.
- id_redirect=1 alone → id_rst=1. id_redirect with load_stall → id_rst=0, stall asserted. rst during MEM_WAIT → state=0, counters 0.
